// File: rtl/adc_sample_conditioner_if.sv
// Bus between the ADC source and the sample conditioner, plus the FSM debug view.
// Strobe/valid semantics: strb_i is asynchronous and only its rising edge matters.
// data_i must be stable from that edge until the sample is accepted.
// dataVaild_STRB_o is high for one enabled cycle exactly when value_o is new.
// There is no back-pressure.
// state_dbg_o encoding: 0 = FILL, 1 = RUN, 2 = CFG.
interface adc_sample_conditioner_if #(
  parameter int IN_BITWIDTH  = 8,
  parameter int ADC_BITWIDTH = 6
);
  logic [IN_BITWIDTH-1:0]  data_i;
  logic                    strb_i;
  logic                    config_en_i;
  logic [ADC_BITWIDTH-1:0] value_o;
  logic                    dataVaild_STRB_o;
  logic                    stale_o;
  logic [1:0]              state_dbg_o;

  modport master (
    output data_i, strb_i, config_en_i,
    input  value_o, dataVaild_STRB_o, stale_o, state_dbg_o
  );

  modport slave (
    input  data_i, strb_i, config_en_i,
    output value_o, dataVaild_STRB_o, stale_o, state_dbg_o
  );
endinterface

// File: rtl/adc_sample_conditioner.sv
// Synchronizes the ADC strobe, truncates the raw sample and then either
// boxcar-averages it (run mode) or bypasses it (config mode). Also flags a stale sensor.
module adc_sample_conditioner #(
  parameter int IN_BITWIDTH    = 8,
  parameter int ADC_BITWIDTH   = 6,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 20000000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  adc_sample_conditioner_if.slave   bus
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = ADC_BITWIDTH + AVG_LOG2;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_CFG  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_s1;
  logic                    r_s2;
  logic                    r_s3;
  logic                    w_accept;
  logic [ADC_BITWIDTH-1:0] w_sample;
  logic [ADC_BITWIDTH-1:0] r_buf [DEPTH];
  logic [AVG_LOG2-1:0]     r_ptr;
  logic [SUM_W-1:0]        r_sum;
  logic [SUM_W-1:0]        w_sum_next;
  logic [AVG_LOG2:0]       r_fill;
  logic                    w_fill_last;
  logic [ADC_BITWIDTH-1:0] r_value;
  logic                    r_valid;
  logic [CNT_W-1:0]        r_stale_cnt;

  assign w_accept    = r_s2 & ~r_s3;
  assign w_sample    = bus.data_i[IN_BITWIDTH-1 -: ADC_BITWIDTH];
  // The oldest entry leaves the window as the new sample enters, so the sum never overflows.
  assign w_sum_next  = r_sum - SUM_W'(r_buf[r_ptr]) + SUM_W'(w_sample);
  assign w_fill_last = (r_fill == (AVG_LOG2+1)'(DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (clk_en_i) begin
      r_s1 <= bus.strb_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_FILL;
    end else if (clk_en_i) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL: begin
        if (bus.config_en_i)            w_state_next = ST_CFG;
        else if (w_accept && w_fill_last) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.config_en_i) w_state_next = ST_CFG;
      end
      ST_CFG: begin
        if (!bus.config_en_i) w_state_next = ST_FILL;
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  // The CFG state keeps the window empty, so leaving CFG is the same as starting a fresh fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_fill  <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
    end else if (clk_en_i) begin
      r_valid <= 1'b0;
      if (bus.config_en_i) begin
        for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        r_ptr  <= '0;
        r_sum  <= '0;
        r_fill <= '0;
        if (w_accept) begin
          r_value <= w_sample;
          r_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_buf[r_ptr] <= w_sample;
        r_sum        <= w_sum_next;
        r_ptr        <= r_ptr + AVG_LOG2'(1);
        if (r_state == ST_RUN) begin
          r_value <= w_sum_next[SUM_W-1:AVG_LOG2];
          r_valid <= 1'b1;
        end else begin
          r_fill <= r_fill + (AVG_LOG2+1)'(1);
          if (w_fill_last) begin
            r_value <= w_sum_next[SUM_W-1:AVG_LOG2];
            r_valid <= 1'b1;
          end
        end
      end
    end
  end

  // An accept wins over the increment, so stale drops on the accept edge itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stale_cnt <= '0;
    end else if (clk_en_i) begin
      if (w_accept) begin
        r_stale_cnt <= '0;
      end else if (r_stale_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        r_stale_cnt <= r_stale_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.value_o          = r_value;
  assign bus.dataVaild_STRB_o = r_valid;
  assign bus.stale_o          = (r_stale_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign bus.state_dbg_o      = r_state;
endmodule
